// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, subordinate state encoding and the byte-lane mask helper.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3
    } hsize_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } sub_state_e;

    localparam int MAX_LANES = 8;

    // Lanes touched by a transfer of 2^hsize bytes starting at byte lane addr_lsbs.
    function automatic logic [MAX_LANES-1:0] size_lane_mask(
        input logic [2:0] addr_lsbs,
        input logic [2:0] hsize
    );
        logic [15:0] span;
        span = (16'd1 << (16'd1 << hsize)) - 16'd1;
        return MAX_LANES'(span << addr_lsbs);
    endfunction

endpackage

// File: rtl/ahb_sub_mem.sv
// Word-organised storage with per-byte write enables and a combinational read port.
module ahb_sub_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    localparam int IDX_W     = $clog2(DEPTH),
    localparam int LANES     = DATA_WIDTH / 8
) (
    input  logic                  HCLK,
    input  logic [IDX_W-1:0]      idx,
    input  logic [LANES-1:0]      byte_we,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge HCLK) begin
        for (int b = 0; b < LANES; b++) begin
            if (byte_we[b]) begin
                mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite subordinate backed by a register-array memory, with optional wait states
// and the two-cycle ERROR response for out-of-range, misaligned or oversized accesses.
module ahb_sram_subordinate
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_BYTES   = 4096,
    parameter int WAIT_STATES = 0
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    HSELx,
    input  logic [ADDR_WIDTH-1:0]   HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [2:0]              HBURST,
    input  logic [3:0]              HPROT,
    input  logic                    HMASTLOCK,
    input  logic [DATA_WIDTH-1:0]   HWDATA,
    input  logic [DATA_WIDTH/8-1:0] HWSTRB,
    input  logic                    HREADY,
    output logic [DATA_WIDTH-1:0]   HRDATA,
    output logic                    HREADYOUT,
    output logic                    HRESP
);

    localparam int LANES  = DATA_WIDTH / 8;
    localparam int LANE_W = $clog2(LANES);
    localparam int MEM_AW = $clog2(MEM_BYTES);
    localparam int DEPTH  = MEM_BYTES / LANES;
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_BYTES);

    sub_state_e state_q, state_d;
    sub_state_e launch_state;
    logic [3:0] wcnt_q, wcnt_d, launch_cnt;

    logic                  accept;
    logic                  take;
    logic                  addr_err;
    logic                  final_cyc;
    logic [MEM_AW-1:0]     haddr_p1;
    logic                  hwrite_p1;
    logic [2:0]            hsize_p1;
    logic [LANES-1:0]      byte_we;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  unused_inputs;

    assign unused_inputs = ^{HPROT, HMASTLOCK, HBURST, HTRANS[0]};

    // ---- address phase: qualification and legality check ----
    assign accept = HSELx && HREADY && HTRANS[1];

    always_comb begin
        addr_err = 1'b0;
        if ({1'b0, HADDR} >= MEM_LIMIT) begin
            addr_err = 1'b1;
        end
        if ((HADDR & ((ADDR_WIDTH'(1) << HSIZE) - ADDR_WIDTH'(1))) != '0) begin
            addr_err = 1'b1;
        end
        if (HSIZE > 3'(LANE_W)) begin
            addr_err = 1'b1;
        end
    end

    // Where an accepted transfer goes; only consulted from cycles that drive HREADYOUT high.
    always_comb begin
        launch_state = ST_IDLE;
        launch_cnt   = 4'd0;
        if (accept) begin
            if (addr_err) begin
                launch_state = ST_ERR1;
            end else begin
                launch_state = ST_DATA;
                launch_cnt   = 4'(WAIT_STATES);
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        final_cyc = 1'b0;
        take      = 1'b0;
        case (state_q)
            ST_DATA: begin
                if (wcnt_q != 4'd0) begin
                    HREADYOUT = 1'b0;
                    wcnt_d    = wcnt_q - 4'd1;
                end else begin
                    final_cyc = 1'b1;
                    take      = accept;
                    state_d   = launch_state;
                    wcnt_d    = launch_cnt;
                end
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP   = HRESP_ERROR;
                take    = accept;
                state_d = launch_state;
                wcnt_d  = launch_cnt;
            end
            default: begin
                take    = accept;
                state_d = launch_state;
                wcnt_d  = launch_cnt;
            end
        endcase
    end

    // ---- data phase: captured address-phase controls ----
    always_ff @(posedge HCLK) begin
        if (take) begin
            haddr_p1  <= HADDR[MEM_AW-1:0];
            hwrite_p1 <= HWRITE;
            hsize_p1  <= HSIZE;
        end
    end

    // A reset arriving on the closing edge abandons the write.
    assign byte_we = (final_cyc && hwrite_p1 && !HRESET)
                   ? (HWSTRB & LANES'(size_lane_mask(3'(haddr_p1[LANE_W-1:0]), hsize_p1)))
                   : '0;

    ahb_sub_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .HCLK    (HCLK),
        .idx     (haddr_p1[MEM_AW-1:LANE_W]),
        .byte_we (byte_we),
        .wdata   (HWDATA),
        .rdata   (mem_rdata)
    );

    assign HRDATA = (final_cyc && !hwrite_p1) ? mem_rdata : '0;

    a_seq_in_burst: assert property (@(posedge HCLK) disable iff (HRESET)
        (take && HTRANS == HTRANS_SEQ) |-> (HBURST != HBURST_SINGLE));

    a_err_two_cycle: assert property (@(posedge HCLK) disable iff (HRESET)
        (state_q == ST_ERR1) |=> (state_q == ST_ERR2));

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Directed bench for ahb_sram_subordinate: a zero-wait instance and a three-wait instance
// share the manager-side signals and are selected individually.
module tb_ahb_sram_subordinate;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        hsel0, hsel3;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [3:0]  hwstrb;
    logic        hready_ext;
    logic [31:0] hrdata0, hrdata3;
    logic        hreadyout0, hreadyout3, hresp0, hresp3;
    logic        hready;

    int checks = 0;
    int errors = 0;

    always #5 HCLK = ~HCLK;

    assign hready = hready_ext & hreadyout0 & hreadyout3;

    ahb_sram_subordinate #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_BYTES(4096), .WAIT_STATES(0)) dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSELx(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0),
        .HWDATA(hwdata), .HWSTRB(hwstrb), .HREADY(hready),
        .HRDATA(hrdata0), .HREADYOUT(hreadyout0), .HRESP(hresp0)
    );

    ahb_sram_subordinate #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_BYTES(4096), .WAIT_STATES(3)) dut3 (
        .HCLK(HCLK), .HRESET(HRESET), .HSELx(hsel3), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0),
        .HWDATA(hwdata), .HWSTRB(hwstrb), .HREADY(hready),
        .HRDATA(hrdata3), .HREADYOUT(hreadyout3), .HRESP(hresp3)
    );

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic addr_phase(input bit sel3, input logic [31:0] a, input bit w, input logic [2:0] sz);
        hsel0  = !sel3;
        hsel3  = sel3;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
        htrans = 2'b10;
    endtask

    task automatic idle_bus();
        hsel0  = 1'b0;
        hsel3  = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
    endtask

    // Single non-pipelined read; returns data from the ready data-phase cycle.
    task automatic rd(input bit sel3, input logic [31:0] a, output logic [31:0] data, output bit tmo);
        addr_phase(sel3, a, 1'b0, 3'd2);
        cyc();
        idle_bus();
        tmo  = 1'b1;
        data = 32'hxxxxxxxx;
        for (int i = 0; i < 20; i++) begin
            @(negedge HCLK);
            if ((sel3 ? hreadyout3 : hreadyout0) === 1'b1) begin
                data = sel3 ? hrdata3 : hrdata0;
                tmo  = 1'b0;
                break;
            end
            cyc();
        end
        cyc();
    endtask

    task automatic wr(input bit sel3, input logic [31:0] a, input logic [31:0] d, output bit tmo);
        addr_phase(sel3, a, 1'b1, 3'd2);
        cyc();
        idle_bus();
        hwdata = d;
        hwstrb = 4'hF;
        tmo    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge HCLK);
            if ((sel3 ? hreadyout3 : hreadyout0) === 1'b1) begin
                tmo = 1'b0;
                break;
            end
            cyc();
        end
        cyc();
        hwstrb = 4'h0;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        idle_bus();
        haddr = '0; hsize = '0; hwdata = '0; hwstrb = '0; hready_ext = 1'b1;
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;
        @(negedge HCLK);
        checks++; if (hreadyout0 !== 1'b1) begin errors++; $display("FAIL reset_ready0 got=%b exp=1", hreadyout0); end
        checks++; if (hresp0 !== 1'b0) begin errors++; $display("FAIL reset_resp0 got=%b exp=0", hresp0); end
        checks++; if (hrdata0 !== 32'h0) begin errors++; $display("FAIL reset_rdata0 got=%h exp=0", hrdata0); end
        checks++; if (hreadyout3 !== 1'b1) begin errors++; $display("FAIL reset_ready3 got=%b exp=1", hreadyout3); end
        checks++; if (hresp3 !== 1'b0) begin errors++; $display("FAIL reset_resp3 got=%b exp=0", hresp3); end
        checks++; if (hrdata3 !== 32'h0) begin errors++; $display("FAIL reset_rdata3 got=%h exp=0", hrdata3); end
        cyc();
    endtask

    task automatic test_back_to_back();
        addr_phase(1'b0, 32'h10, 1'b1, 3'd2);
        cyc();
        hwdata = 32'hDEADBEEF; hwstrb = 4'hF;
        addr_phase(1'b0, 32'h10, 1'b0, 3'd2);
        @(negedge HCLK);
        checks++; if (hreadyout0 !== 1'b1) begin errors++; $display("FAIL b2b_wr_ready got=%b exp=1", hreadyout0); end
        checks++; if (hresp0 !== 1'b0) begin errors++; $display("FAIL b2b_wr_resp got=%b exp=0", hresp0); end
        cyc();
        idle_bus(); hwdata = '0; hwstrb = '0;
        @(negedge HCLK);
        checks++; if (hrdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_rd_data got=%h exp=deadbeef", hrdata0); end
        checks++; if (hreadyout0 !== 1'b1) begin errors++; $display("FAIL b2b_rd_ready got=%b exp=1", hreadyout0); end
        checks++; if (hresp0 !== 1'b0) begin errors++; $display("FAIL b2b_rd_resp got=%b exp=0", hresp0); end
        cyc();
        @(negedge HCLK);
        checks++; if (hrdata0 !== 32'h0) begin errors++; $display("FAIL b2b_rdata_idle got=%h exp=0", hrdata0); end
        cyc();
    endtask

    task automatic test_byte_lanes();
        logic [31:0] strb_tab [2];
        logic [31:0] data_tab [2];
        logic [31:0] exp_tab  [2];
        strb_tab[0] = 32'h2; data_tab[0] = 32'h0000AA00; exp_tab[0] = 32'h1122AA44;
        strb_tab[1] = 32'hF; data_tab[1] = 32'hFFFFBBFF; exp_tab[1] = 32'h1122BB44;
        for (int k = 0; k < 2; k++) begin
            addr_phase(1'b0, 32'h10, 1'b1, 3'd2);
            cyc();
            hwdata = 32'h11223344; hwstrb = 4'hF;
            addr_phase(1'b0, 32'h11, 1'b1, 3'd0);
            cyc();
            hwdata = data_tab[k]; hwstrb = strb_tab[k][3:0];
            addr_phase(1'b0, 32'h10, 1'b0, 3'd2);
            cyc();
            idle_bus(); hwdata = '0; hwstrb = '0;
            @(negedge HCLK);
            checks++; if (hrdata0 !== exp_tab[k]) begin errors++; $display("FAIL byte_lane_%0d got=%h exp=%h", k, hrdata0, exp_tab[k]); end
            cyc();
        end
    endtask

    task automatic test_wait_states();
        addr_phase(1'b1, 32'h20, 1'b1, 3'd2);
        cyc();
        hwdata = 32'hCAFEF00D; hwstrb = 4'hF;
        addr_phase(1'b1, 32'h20, 1'b0, 3'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            checks++; if (hreadyout3 !== 1'b0) begin errors++; $display("FAIL ws_wr_wait%0d got=%b exp=0", i, hreadyout3); end
            cyc();
        end
        @(negedge HCLK);
        checks++; if (hreadyout3 !== 1'b1) begin errors++; $display("FAIL ws_wr_final_ready got=%b exp=1", hreadyout3); end
        checks++; if (hresp3 !== 1'b0) begin errors++; $display("FAIL ws_wr_final_resp got=%b exp=0", hresp3); end
        cyc();
        idle_bus(); hwdata = '0; hwstrb = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            checks++; if (hreadyout3 !== 1'b0) begin errors++; $display("FAIL ws_rd_wait%0d got=%b exp=0", i, hreadyout3); end
            cyc();
        end
        @(negedge HCLK);
        checks++; if (hreadyout3 !== 1'b1) begin errors++; $display("FAIL ws_rd_final_ready got=%b exp=1", hreadyout3); end
        checks++; if (hrdata3 !== 32'hCAFEF00D) begin errors++; $display("FAIL ws_rd_data got=%h exp=cafef00d", hrdata3); end
        checks++; if (hresp3 !== 1'b0) begin errors++; $display("FAIL ws_rd_resp got=%b exp=0", hresp3); end
        cyc();
        @(negedge HCLK);
        checks++; if (hrdata3 !== 32'h0) begin errors++; $display("FAIL ws_rdata_idle got=%h exp=0", hrdata3); end
        cyc();
    endtask

    task automatic test_error();
        bit tmo;
        wr(1'b0, 32'h0, 32'hA5A5A5A5, tmo);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL err_preload_timeout got=%b exp=0", tmo); end
        addr_phase(1'b0, 32'h1000, 1'b1, 3'd2);
        cyc();
        idle_bus(); hwdata = 32'h12345678; hwstrb = 4'hF;
        @(negedge HCLK);
        checks++; if (hreadyout0 !== 1'b0) begin errors++; $display("FAIL err_range_err1_ready got=%b exp=0", hreadyout0); end
        checks++; if (hresp0 !== 1'b1) begin errors++; $display("FAIL err_range_err1_resp got=%b exp=1", hresp0); end
        cyc();
        @(negedge HCLK);
        checks++; if (hreadyout0 !== 1'b1) begin errors++; $display("FAIL err_range_err2_ready got=%b exp=1", hreadyout0); end
        checks++; if (hresp0 !== 1'b1) begin errors++; $display("FAIL err_range_err2_resp got=%b exp=1", hresp0); end
        cyc();
        hwstrb = 4'h0;
        addr_phase(1'b0, 32'h12, 1'b0, 3'd2);
        cyc();
        idle_bus();
        @(negedge HCLK);
        checks++; if (hreadyout0 !== 1'b0) begin errors++; $display("FAIL err_align_err1_ready got=%b exp=0", hreadyout0); end
        checks++; if (hresp0 !== 1'b1) begin errors++; $display("FAIL err_align_err1_resp got=%b exp=1", hresp0); end
        checks++; if (hrdata0 !== 32'h0) begin errors++; $display("FAIL err_align_rdata got=%h exp=0", hrdata0); end
        cyc();
        addr_phase(1'b0, 32'h0, 1'b0, 3'd2);
        @(negedge HCLK);
        checks++; if (hreadyout0 !== 1'b1) begin errors++; $display("FAIL err_align_err2_ready got=%b exp=1", hreadyout0); end
        checks++; if (hresp0 !== 1'b1) begin errors++; $display("FAIL err_align_err2_resp got=%b exp=1", hresp0); end
        cyc();
        idle_bus();
        @(negedge HCLK);
        checks++; if (hrdata0 !== 32'hA5A5A5A5) begin errors++; $display("FAIL err_mem_unchanged got=%h exp=a5a5a5a5", hrdata0); end
        checks++; if (hresp0 !== 1'b0) begin errors++; $display("FAIL err_after_resp got=%b exp=0", hresp0); end
        cyc();
        addr_phase(1'b0, 32'h8, 1'b0, 3'd3);
        cyc();
        idle_bus();
        @(negedge HCLK);
        checks++; if (hresp0 !== 1'b1 || hreadyout0 !== 1'b0) begin errors++; $display("FAIL err_size_err1 got=%b/%b exp=1/0", hresp0, hreadyout0); end
        cyc();
        @(negedge HCLK);
        checks++; if (hresp0 !== 1'b1 || hreadyout0 !== 1'b1) begin errors++; $display("FAIL err_size_err2 got=%b/%b exp=1/1", hresp0, hreadyout0); end
        cyc();
    endtask

    task automatic test_no_transfer();
        logic [31:0] d;
        bit tmo;
        for (int k = 0; k < 4; k++) begin
            haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2; hsel3 = 1'b0;
            case (k)
                0:       begin hsel0 = 1'b0; htrans = 2'b10; end
                1:       begin hsel0 = 1'b1; htrans = 2'b01; end
                2:       begin hsel0 = 1'b1; htrans = 2'b00; end
                default: begin hsel0 = 1'b1; htrans = 2'b10; hready_ext = 1'b0; end
            endcase
            cyc();
            hready_ext = 1'b1;
            idle_bus(); hwdata = 32'hFFFFFFFF; hwstrb = 4'hF;
            @(negedge HCLK);
            checks++; if (hreadyout0 !== 1'b1) begin errors++; $display("FAIL nox_ready_%0d got=%b exp=1", k, hreadyout0); end
            checks++; if (hresp0 !== 1'b0) begin errors++; $display("FAIL nox_resp_%0d got=%b exp=0", k, hresp0); end
            cyc();
            hwstrb = 4'h0;
        end
        rd(1'b0, 32'h10, d, tmo);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL nox_read_timeout got=%b exp=0", tmo); end
        checks++; if (d !== 32'h1122BB44) begin errors++; $display("FAIL nox_mem_unchanged got=%h exp=1122bb44", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bit tmo;
        addr_phase(1'b1, 32'h20, 1'b1, 3'd2);
        cyc();
        idle_bus(); hwdata = 32'h0BADF00D; hwstrb = 4'hF;
        @(negedge HCLK);
        checks++; if (hreadyout3 !== 1'b0) begin errors++; $display("FAIL rstmid_wait got=%b exp=0", hreadyout3); end
        cyc();
        HRESET = 1'b1;
        cyc();
        HRESET = 1'b0;
        @(negedge HCLK);
        checks++; if (hreadyout3 !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", hreadyout3); end
        checks++; if (hresp3 !== 1'b0) begin errors++; $display("FAIL rstmid_resp got=%b exp=0", hresp3); end
        checks++; if (hrdata3 !== 32'h0) begin errors++; $display("FAIL rstmid_rdata got=%h exp=0", hrdata3); end
        repeat (4) cyc();
        hwstrb = 4'h0; hwdata = '0;
        rd(1'b1, 32'h20, d, tmo);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL rstmid_read_timeout got=%b exp=0", tmo); end
        checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL rstmid_mem_unchanged got=%h exp=cafef00d", d); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_byte_lanes();
        test_wait_states();
        test_error();
        test_no_transfer();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
